sgdmac_bdram_arb: RTL and testbench
===================================

SGDMAC_BDRAM_ARB -- requirements
Module: sgdmac_bdram_arb

Interface
REQ-001 SHALL have parameter BD_AWIDTH, default 10, descriptor RAM word-address width.
REQ-002 SHALL have parameter BURST_LEN, default 4, engine descriptor-fetch burst length in words (power of 2, 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have host ports: h_req in 1 access request; h_we in 1 write(1)/read(0); h_addr in BD_AWIDTH word address; h_wdat in 32 write data; h_gnt out 1 grant pulse; h_rdat out 32 read data; h_rval out 1 read data valid.
REQ-006 SHALL have engine ports: e_req in 1 burst request; e_addr in BD_AWIDTH burst start address; e_gnt out 1 grant pulse; e_rdat out 32 read data; e_rval out 1 read data valid; e_last out 1 final word of burst.
REQ-007 SHALL have RAM ports: bd_waddr out BD_AWIDTH; bd_raddr out BD_AWIDTH; bd_wdat out 32; bd_we out 1; bd_re out 1; bd_rdat in 32 (RAM output registered, data valid 2 cycles after bd_re).

Function
REQ-008 SHALL implement FSM IDLE, HOST, ENG.
REQ-009 IDLE: SHALL evaluate h_req/e_req each cycle; winner gets a one-cycle gnt combinationally in that cycle, address/we/wdat captured at that edge, FSM moves to HOST or ENG.
REQ-010 Requester SHALL hold req and request fields stable until it sees gnt, then may drop req; gnt is the only acknowledge.
REQ-011 HOST (exactly 1 cycle): bd_we=captured h_we, bd_re=!captured h_we, bd_waddr/bd_raddr=captured h_addr, bd_wdat=captured h_wdat; then IDLE.
REQ-012 ENG (exactly BURST_LEN cycles): bd_re=1, bd_raddr=captured e_addr+k for k=0..BURST_LEN-1, sum truncated to BD_AWIDTH (wrap at 2^BD_AWIDTH-1 to 0); bd_we=0; then IDLE.
REQ-013 Host read latency: gnt at N, bd_re at N+1, h_rval=1 with h_rdat=bd_rdat at N+3; host write produces no h_rval.
REQ-014 Engine latency: gnt at N, e_rval at N+3..N+2+BURST_LEN, e_last only at N+2+BURST_LEN.
REQ-015 SHALL route return data by a 2-stage owner tag pipeline (host/engine/none) shifted every cycle; rval only for the tagged owner; h_rdat/e_rdat may equal bd_rdat unconditionally.
REQ-016 No grant SHALL be issued outside IDLE; minimum one IDLE cycle between accesses.
REQ-017 Simultaneous h_req and e_req in IDLE: round robin; winner is requester not served last; last-served pointer updated on every gnt.
REQ-018 bd_we and bd_re SHALL never both be 1; both 0 in IDLE.

Reset
REQ-019 On rstn low (asynchronous): FSM=IDLE, burst counter=0, tag pipeline=none, last-served=engine, captured fields=0.
REQ-020 All outputs SHALL be 0 during reset and in the cycle after release absent requests.
REQ-021 Reset mid-burst or mid-read SHALL abort; no h_rval/e_rval/e_last for the aborted access after release.

Configuration
REQ-022 Macro SGDMAC_BDARB_HOSTPRIO_EN defined: simultaneous requests in IDLE always granted to host (fixed priority), last-served pointer unused.
REQ-023 Macro undefined: round robin per REQ-017.

Verification
REQ-024 Host write h_addr=0x010, h_wdat=0xDEADBEEF, then host read 0x010 -> bd_we one cycle after gnt with matching addr/data; h_rval 3 cycles after read gnt, h_rdat=0xDEADBEEF.
REQ-025 Engine burst e_addr=0x020 over preloaded words -> bd_raddr 0x020..0x023 on consecutive cycles; 4 e_rval pulses in order; e_last only on 4th.
REQ-026 e_addr=0x3FE (BD_AWIDTH=10) -> bd_raddr 0x3FE,0x3FF,0x000,0x001.
REQ-027 h_req and e_req high together from reset, held -> grant order host, engine, host, engine (macro undefined); host, host, ... when host re-requests (macro defined).
REQ-028 rstn low at 2nd cycle of engine burst, released -> no e_rval/e_last afterward; FSM IDLE; next h_req granted next cycle.
REQ-029 Random mixed traffic 1000 accesses vs reference memory model -> all read data match, never bd_we&&bd_re, no gnt outside IDLE.

Source files
------------

// File: rtl/sgdmac_bdram_arb.sv
// ---------------------------------------------------------------------------
// sgdmac_bdram_arb
//   Arbitrates a single-port descriptor RAM between a host port (single word
//   read/write) and the DMA engine (fixed-length read bursts). One access is
//   serviced at a time, with at least one IDLE cycle between accesses.
//
//   Returned read data is steered by a 2-stage owner tag pipeline. This
//   matches the RAM's 2-cycle registered read latency.
//
// Parameters
//   BD_AWIDTH  descriptor RAM word-address width
//   BURST_LEN  engine burst length in words (power of 2, 2..8)
//
// Ports
//   clk, rstn                 clock, async active-low reset
//   h_req/h_we/h_addr/h_wdat  host request; held stable until h_gnt
//   h_gnt/h_rdat/h_rval       host grant pulse, read data and valid
//   e_req/e_addr              engine burst request; held stable until e_gnt
//   e_gnt/e_rdat/e_rval/e_last engine grant, read data, valid, last word
//   bd_*                      RAM write/read ports; bd_rdat is valid 2 cycles
//                             after bd_re
//
// Configuration
//   SGDMAC_BDARB_HOSTPRIO_EN  when defined, the host always wins when both
//                             requesters are active. When undefined,
//                             simultaneous requests are served round robin.
// ---------------------------------------------------------------------------
module sgdmac_bdram_arb #(
    parameter int BD_AWIDTH = 10,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    // host port
    input  logic                 h_req,
    input  logic                 h_we,
    input  logic [BD_AWIDTH-1:0] h_addr,
    input  logic [31:0]          h_wdat,
    output logic                 h_gnt,
    output logic [31:0]          h_rdat,
    output logic                 h_rval,
    // engine port
    input  logic                 e_req,
    input  logic [BD_AWIDTH-1:0] e_addr,
    output logic                 e_gnt,
    output logic [31:0]          e_rdat,
    output logic                 e_rval,
    output logic                 e_last,
    // descriptor RAM
    output logic [BD_AWIDTH-1:0] bd_waddr,
    output logic [BD_AWIDTH-1:0] bd_raddr,
    output logic [31:0]          bd_wdat,
    output logic                 bd_we,
    output logic                 bd_re,
    input  logic [31:0]          bd_rdat
);

    localparam int CW = $clog2(BURST_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_HOST, ST_ENG} state_t;

    // Owner of a read in flight. The final engine word carries its own tag so
    // that e_last is generated without a second counter on the return side.
    typedef enum logic [1:0] {TAG_NONE, TAG_HOST, TAG_ENG, TAG_ELAST} tag_t;

    typedef struct packed {
        logic                 we;
        logic [BD_AWIDTH-1:0] addr;
        logic [31:0]          wdat;
    } host_cap_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic                 cnt_last;
    host_cap_t            host_cap;
    logic [BD_AWIDTH-1:0] eng_addr;
    logic                 host_win, eng_win;
    tag_t                 tag_issue;
    tag_t [2:1]           tag_pipe;

`ifndef SGDMAC_BDARB_HOSTPRIO_EN
    logic                 last_eng;   // 1: engine was granted most recently
`endif

    // ------------------------------------------------------------------
    // Arbitration. A grant is issued only in IDLE and is combinational, so
    // the requester sees it in the same cycle that its fields are captured.
    // ------------------------------------------------------------------
    always_comb begin
        host_win = 1'b0;
        eng_win  = 1'b0;
        if (state == ST_IDLE) begin
`ifdef SGDMAC_BDARB_HOSTPRIO_EN
            host_win = h_req;
            eng_win  = e_req && !h_req;
`else
            if (h_req && e_req) begin
                host_win = last_eng;
                eng_win  = !last_eng;
            end else begin
                host_win = h_req;
                eng_win  = e_req;
            end
`endif
        end
    end

    assign h_gnt    = host_win;
    assign e_gnt    = eng_win;
    assign cnt_last = (cnt == CW'(BURST_LEN - 1));

    // ------------------------------------------------------------------
    // Next state and RAM drive. The RAM buses are forced to zero outside an
    // access so that the outputs stay quiet in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        bd_we     = 1'b0;
        bd_re     = 1'b0;
        bd_waddr  = '0;
        bd_raddr  = '0;
        bd_wdat   = '0;
        tag_issue = TAG_NONE;
        case (state)
            ST_IDLE: begin
                if (host_win)     state_nxt = ST_HOST;
                else if (eng_win) state_nxt = ST_ENG;
            end
            ST_HOST: begin
                bd_we     = host_cap.we;
                bd_re     = !host_cap.we;
                bd_waddr  = host_cap.addr;
                bd_raddr  = host_cap.addr;
                bd_wdat   = host_cap.wdat;
                tag_issue = host_cap.we ? TAG_NONE : TAG_HOST;
                state_nxt = ST_IDLE;
            end
            ST_ENG: begin
                bd_re     = 1'b1;
                // Wraps naturally at the top of the address space.
                bd_raddr  = eng_addr + BD_AWIDTH'(cnt);
                tag_issue = cnt_last ? TAG_ELAST : TAG_ENG;
                if (cnt_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, burst counter, captured request fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            host_cap <= '0;
            eng_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_ENG && !cnt_last) cnt <= cnt + CW'(1);
            else                              cnt <= '0;
            if (host_win) host_cap <= '{we: h_we, addr: h_addr, wdat: h_wdat};
            if (eng_win)  eng_addr <= e_addr;
        end
    end

`ifndef SGDMAC_BDARB_HOSTPRIO_EN
    // The reset value of "engine" makes the host win the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         last_eng <= 1'b1;
        else if (host_win) last_eng <= 1'b0;
        else if (eng_win)  last_eng <= 1'b1;
    end
`endif

    // ------------------------------------------------------------------
    // Return-data steering. The tag issued with bd_re reaches stage 2 in the
    // cycle that bd_rdat holds the corresponding word. Reset flushes the
    // tags, so an aborted access never produces a valid pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tag_pipe <= {TAG_NONE, TAG_NONE};
        else       tag_pipe <= {tag_pipe[1], tag_issue};
    end

    assign h_rval = (tag_pipe[2] == TAG_HOST);
    assign e_rval = (tag_pipe[2] == TAG_ENG) || (tag_pipe[2] == TAG_ELAST);
    assign e_last = (tag_pipe[2] == TAG_ELAST);
    assign h_rdat = h_rval ? bd_rdat : 32'h0;
    assign e_rdat = e_rval ? bd_rdat : 32'h0;

endmodule

// File: tb/tb_sgdmac_bdram_arb.sv
// ---------------------------------------------------------------------------
// tb_sgdmac_bdram_arb
//   Directed plus random-traffic bench for sgdmac_bdram_arb. The bench has a
//   behavioural RAM with 2-cycle read latency and a reference memory that is
//   updated at grant time. A background monitor watches for bd_we/bd_re
//   overlap and for grants issued during a busy access.
// ---------------------------------------------------------------------------
module tb_sgdmac_bdram_arb;

    localparam int AW = 10;
    localparam int BL = 4;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          h_req, h_we, e_req;
    logic [AW-1:0] h_addr, e_addr;
    logic [31:0]   h_wdat;
    logic          h_gnt, h_rval, e_gnt, e_rval, e_last;
    logic [31:0]   h_rdat, e_rdat;
    logic [AW-1:0] bd_waddr, bd_raddr;
    logic [31:0]   bd_wdat;
    logic          bd_we, bd_re;
    logic [31:0]   bd_rdat = 32'h0;

    always #5 clk = ~clk;

    sgdmac_bdram_arb #(.BD_AWIDTH(AW), .BURST_LEN(BL)) dut (
        .clk(clk), .rstn(rstn),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdat(h_wdat),
        .h_gnt(h_gnt), .h_rdat(h_rdat), .h_rval(h_rval),
        .e_req(e_req), .e_addr(e_addr), .e_gnt(e_gnt), .e_rdat(e_rdat),
        .e_rval(e_rval), .e_last(e_last),
        .bd_waddr(bd_waddr), .bd_raddr(bd_raddr), .bd_wdat(bd_wdat),
        .bd_we(bd_we), .bd_re(bd_re), .bd_rdat(bd_rdat)
    );

    logic [122:0] all_out;
    assign all_out = {h_gnt, h_rdat, h_rval, e_gnt, e_rdat, e_rval, e_last,
                      bd_waddr, bd_raddr, bd_wdat, bd_we, bd_re};

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ 32'(i * 32'h0001_0003);
    endfunction

    // RAM model: registered array read, then an output register.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rd_q1 = 32'h0;
    logic        init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= init_word(i);
            init_done <= 1'b1;
        end else if (bd_we) begin
            mem[bd_waddr] <= bd_wdat;
        end
        rd_q1   <= mem[bd_raddr];
        bd_rdat <= rd_q1;
    end

    // Protocol monitor
    int viol = 0;
    int busy = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            busy <= 0;
        end else begin
            viol <= viol + int'(bd_we && bd_re) + int'(h_gnt && e_gnt)
                         + int'(busy > 0 && (h_gnt || e_gnt));
            if (busy > 0)   busy <= busy - 1;
            else if (h_gnt) busy <= 1;
            else if (e_gnt) busy <= BL;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ref_mem [0:(1<<AW)-1];

    task automatic eng_burst(input logic [AW-1:0] a);
        logic [AW-1:0] ea;
        e_req  = 1'b1;
        e_addr = a;
        #1 chk($sformatf("eng_gnt_%0h", a), 128'({h_gnt, e_gnt}), 128'(2'b01));
        for (int j = 1; j <= BL + 3; j++) begin
            tick();
            e_req = 1'b0;
            #1;
            if (j <= BL) begin
                ea = a + AW'(j - 1);
                chk($sformatf("eng_raddr_%0h_%0d", a, j), 128'(bd_raddr), 128'(ea));
                chk($sformatf("eng_wr_re_%0h_%0d", a, j), 128'({bd_we, bd_re}), 128'(2'b01));
            end
            chk($sformatf("eng_rval_last_%0h_%0d", a, j), 128'({e_rval, e_last}),
                128'({(j >= 3 && j <= BL + 2), (j == BL + 2)}));
            if (j >= 3 && j <= BL + 2) begin
                ea = a + AW'(j - 3);
                chk($sformatf("eng_rdat_%0h_%0d", a, j), 128'(e_rdat), 128'(ref_mem[ea]));
            end
        end
    endtask

    // Random-phase scoreboard
    logic [31:0] hq[$];
    logic [32:0] eq[$];
    int          rnd_err = 0;
    int          rd_seen = 0;

    task automatic rnd_sample();
        if (h_rval) begin
            if (hq.size() == 0 || h_rdat !== hq[0]) rnd_err++;
            if (hq.size() != 0) void'(hq.pop_front());
            rd_seen++;
        end
        if (e_rval) begin
            if (eq.size() == 0 || {e_last, e_rdat} !== eq[0]) rnd_err++;
            if (eq.size() != 0) void'(eq.pop_front());
            rd_seen++;
        end else if (e_last) begin
            rnd_err++;
        end
    endtask

    logic [3:0]    seq;
    logic [3:0]    seq_exp;
    int            ng, erv, grants;
    logic          hg, eg;
    logic [AW-1:0] ea_r;

    initial begin
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdat = '0;
        e_req = 1'b0; e_addr = '0;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_word(i);

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", 128'(all_out), 128'(0));
        rstn = 1'b1;
        #1 chk("post_reset_idle", 128'(all_out), 128'(0));
        tick();

        // ---- host write 0x010 = DEADBEEF ----
        h_req = 1'b1; h_we = 1'b1; h_addr = 10'h010; h_wdat = 32'hDEAD_BEEF;
        #1 chk("wr_gnt", 128'({h_gnt, e_gnt}), 128'(2'b10));
        tick();
        h_req = 1'b0; h_we = 1'b0; h_wdat = 32'h0;
        #1;
        chk("wr_we_re", 128'({bd_we, bd_re}), 128'(2'b10));
        chk("wr_waddr", 128'(bd_waddr), 128'(10'h010));
        chk("wr_wdat", 128'(bd_wdat), 128'(32'hDEAD_BEEF));
        ref_mem[10'h010] = 32'hDEAD_BEEF;
        tick();
        #1 chk("wr_idle_after", 128'({bd_we, bd_re, h_rval}), 128'(0));

        // ---- host read 0x010 ----
        h_req = 1'b1; h_addr = 10'h010;
        #1 chk("rd_gnt", 128'(h_gnt), 128'(1));
        tick();
        h_req = 1'b0;
        #1;
        chk("rd_we_re", 128'({bd_we, bd_re}), 128'(2'b01));
        chk("rd_raddr", 128'(bd_raddr), 128'(10'h010));
        chk("rd_rval_n1", 128'(h_rval), 128'(0));
        tick();
        #1 chk("rd_rval_n2", 128'(h_rval), 128'(0));
        tick();
        #1;
        chk("rd_rval_n3", 128'(h_rval), 128'(1));
        chk("rd_rdat_n3", 128'(h_rdat), 128'(32'hDEAD_BEEF));
        chk("rd_no_erval", 128'(e_rval), 128'(0));
        tick();
        #1 chk("rd_rval_n4", 128'(h_rval), 128'(0));

        // ---- engine bursts, including address wrap ----
        eng_burst(10'h020);
        eng_burst(10'h3FE);

        // ---- simultaneous requests held from reset ----
        rstn = 1'b0;
        h_req = 1'b1; h_we = 1'b0; h_addr = 10'h005;
        e_req = 1'b1; e_addr = 10'h100;
        tick(); tick();
        rstn = 1'b1;
        ng = 0; seq = '0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            #1;
            if (h_gnt) begin seq[ng] = 1'b1; ng++; end
            else if (e_gnt) begin seq[ng] = 1'b0; ng++; end
            tick();
        end
`ifdef SGDMAC_BDARB_HOSTPRIO_EN
        seq_exp = 4'b1111;
`else
        seq_exp = 4'b0101;   // host, engine, host, engine (bit0 first)
`endif
        chk("rr_grant_count", 128'(ng), 128'(4));
        chk("rr_grant_order", 128'(seq), 128'(seq_exp));
        h_req = 1'b0; e_req = 1'b0;
        repeat (10) tick();

        // ---- reset in the 2nd cycle of an engine burst ----
        e_req = 1'b1; e_addr = 10'h040;
        #1 chk("abort_eng_gnt", 128'(e_gnt), 128'(1));
        tick();
        e_req = 1'b0;
        tick();
        rstn = 1'b0;
        #1 chk("abort_outputs_in_reset", 128'(all_out), 128'(0));
        tick();
        rstn = 1'b1;
        #1 chk("abort_idle_after_release", 128'(all_out), 128'(0));
        tick();
        h_req = 1'b1; h_we = 1'b0; h_addr = 10'h010;
        #1 chk("abort_next_host_gnt", 128'(h_gnt), 128'(1));
        erv = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            h_req = 1'b0;
            #1;
            if (e_rval || e_last) erv++;
        end
        chk("abort_no_eng_rval", 128'(erv), 128'(0));

        // ---- random mixed traffic ----
        grants = 0;
        for (int cyc = 0; cyc < 60000 && grants < 1000; cyc++) begin
            if (!h_req && $urandom_range(0, 2) == 0) begin
                h_req  = 1'b1;
                h_we   = 1'($urandom_range(0, 1));
                h_addr = AW'($urandom_range(0, 63));
                h_wdat = $urandom;
            end
            if (!e_req && $urandom_range(0, 3) == 0) begin
                e_req  = 1'b1;
                e_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 63))
                                                     : AW'($urandom_range(1018, 1023));
            end
            #1;
            rnd_sample();
            hg = h_gnt;
            eg = e_gnt;
            if (hg) begin
                grants++;
                if (h_we) ref_mem[h_addr] = h_wdat;
                else      hq.push_back(ref_mem[h_addr]);
            end
            if (eg) begin
                grants++;
                for (int k = 0; k < BL; k++) begin
                    ea_r = e_addr + AW'(k);
                    eq.push_back({(k == BL - 1), ref_mem[ea_r]});
                end
            end
            tick();
            if (hg) h_req = 1'b0;
            if (eg) e_req = 1'b0;
        end
        h_req = 1'b0; e_req = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            rnd_sample();
            tick();
        end
        chk("rnd_grants", 128'(grants), 128'(1000));
        chk("rnd_data_errors", 128'(rnd_err), 128'(0));
        chk("rnd_host_queue_drained", 128'(hq.size()), 128'(0));
        chk("rnd_eng_queue_drained", 128'(eq.size()), 128'(0));
        chk("rnd_reads_returned", 128'(rd_seen > 500), 128'(1));
        chk("monitor_violations", 128'(viol), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
